// File: rtl/barrel_shifter_pipe.sv
// Pipelined N-bit barrel shifter with five shift/rotate modes. There is one register
// stage per shift-amount bit, the largest shift comes first, and valid/ready is used on both ends.

module barrel_shifter_stage #(
    parameter int N   = 8,
    parameter int SW  = 3,
    parameter int BIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          d_vld,
    input  logic [N-1:0]  d_data,
    input  logic [SW-1:0] d_amt,
    input  logic [2:0]    d_mode,
    input  logic          d_err,
    output logic          q_vld,
    output logic [N-1:0]  q_data,
    output logic [SW-1:0] q_amt,
    output logic [2:0]    q_mode,
    output logic          q_err
);
    localparam int S = 1 << BIT;

    logic [N-1:0] shifted;

    // An ASR fill taken from this stage's input MSB is correct, because earlier ASR stages keep the sign.
    always_comb begin
        shifted = d_data;
        if (!d_err && d_amt[BIT]) begin
            case (d_mode)
                3'd0:    shifted = d_data >> S;
                3'd1:    shifted = d_data << S;
                3'd2:    shifted = $signed(d_data) >>> S;
                3'd3:    shifted = (d_data >> S) | (d_data << (N - S));
                3'd4:    shifted = (d_data << S) | (d_data >> (N - S));
                default: shifted = d_data;
            endcase
        end
    end

    // Valid always moves with the pipe. The payload only loads behind a real op.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld  <= 1'b0;
            q_data <= '0;
            q_amt  <= '0;
            q_mode <= '0;
            q_err  <= 1'b0;
        end else if (advance) begin
            q_vld <= d_vld;
            if (d_vld) begin
                q_data <= shifted;
                q_amt  <= d_amt;
                q_mode <= d_mode;
                q_err  <= d_err;
            end
        end
    end
endmodule

module barrel_shifter_pipe #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_amt,
    input  logic [2:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_zero,
    output logic                 out_err
);
    localparam int SW = $clog2(N);

    logic                 advance;
    logic [SW:0]          vld_pipe;
    logic [SW:0][N-1:0]   data_pipe;
    logic [SW:0][SW-1:0]  amt_pipe;
    logic [SW:0][2:0]     mode_pipe;
    logic [SW:0]          err_pipe;
    logic                 unused_tail;

    // The whole pipe stalls as a unit. Bubbles are never squeezed out.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = in_data;
    assign amt_pipe[0]  = in_amt;
    assign mode_pipe[0] = in_mode;
    assign err_pipe[0]  = (in_mode > 3'd4);

    for (genvar k = 0; k < SW; k++) begin : g_stage
        barrel_shifter_stage #(
            .N   (N),
            .SW  (SW),
            .BIT (SW - 1 - k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .d_vld   (vld_pipe[k]),
            .d_data  (data_pipe[k]),
            .d_amt   (amt_pipe[k]),
            .d_mode  (mode_pipe[k]),
            .d_err   (err_pipe[k]),
            .q_vld   (vld_pipe[k+1]),
            .q_data  (data_pipe[k+1]),
            .q_amt   (amt_pipe[k+1]),
            .q_mode  (mode_pipe[k+1]),
            .q_err   (err_pipe[k+1])
        );
    end

    assign out_valid = vld_pipe[SW];
    assign out_data  = data_pipe[SW];
    assign out_err   = err_pipe[SW];
    // Qualified by valid so that a freshly reset (all-zero) pipe does not flag zero.
    assign out_zero  = vld_pipe[SW] && (data_pipe[SW] == '0);

    // Amount and mode are not needed after the last stage.
    assign unused_tail = ^{amt_pipe[SW], mode_pipe[SW]};
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboarded bench for barrel_shifter_pipe at N=8 (directed), N=16 and N=32 (random sweep).

module tb_barrel_shifter_pipe;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] in_data  [3];
    logic [4:0]  in_amt   [3];
    logic [2:0]  in_mode  [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [31:0] out_data [3];
    logic        out_zero [3];
    logic        out_err  [3];
    logic        rnd_rdy  [3];

    exp_t sb[3][$];
    int   checks = 0;
    int   errors = 0;
    logic lat_on = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = 8 << g;
        localparam int S = $clog2(W);
        logic [W-1:0] od;
        barrel_shifter_pipe #(.N(W)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g][W-1:0]),
            .in_amt    (in_amt[g][S-1:0]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (od),
            .out_zero  (out_zero[g]),
            .out_err   (out_err[g])
        );
        assign out_data[g] = 32'(od);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] din, input int a, input int m, input int w);
        logic [31:0] d   = din;
        logic [31:0] msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        if (m > 4) return d;
        for (int k = 0; k < a; k++) begin
            case (m)
                0:       d = d >> 1;
                1:       d = (d << 1) & msk;
                2:       d = (d >> 1) | (32'(d[w-1]) << (w - 1));
                3:       d = (d >> 1) | (32'(d[0]) << (w - 1));
                default: d = ((d << 1) | 32'(d[w-1])) & msk;
            endcase
        end
        return d;
    endfunction

    // Retire side: compare every handshake against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        chk("spurious_out", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        chk("data", out_data[i], e.data);
                        chk("err", 32'(out_err[i]), 32'(e.err));
                        chk("zero", 32'(out_zero[i]), 32'(e.data == 32'h0));
                        if (lat_on) chk("latency", 32'(cyc - e.t), 32'(3 + i));
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 1; i < 3; i++)
            if (rnd_rdy[i]) out_ready[i] = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int i, input logic [31:0] d, input int a, input int m,
                        input logic [31:0] exp, input logic experr);
        int   k = 0;
        exp_t e;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_amt[i]   = 5'(a);
        in_mode[i]  = 3'(m);
        @(negedge clk);
        while (!in_ready[i] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready[i]) chk("in_ready_timeout", 32'(in_ready[i]), 32'h1);
        e.data = exp;
        e.err  = experr;
        e.t    = cyc;
        sb[i].push_back(e);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_empty(input int i);
        int k = 0;
        while (sb[i].size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", 32'(sb[i].size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int i);
        int          w = 8 << i;
        logic [31:0] msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        logic [31:0] d;
        int          a, m;
        rnd_rdy[i] = 1'b1;
        repeat (1000) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            d = $urandom() & msk;
            a = $urandom_range(0, w - 1);
            m = $urandom_range(0, 7);
            send(i, d, a, m, model(d, a, m, w), m > 4);
        end
        rnd_rdy[i] = 1'b0;
        @(posedge clk);
        #2;
        out_ready[i] = 1'b1;
        wait_empty(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          t0;
        logic [31:0] hold;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_amt[i] = '0; in_mode[i] = '0;
            out_ready[i] = 1'b1; rnd_rdy[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid[0]), 32'h0);
        chk("rst_out_data", out_data[0], 32'h0);
        chk("rst_out_zero", 32'(out_zero[0]), 32'h0);
        chk("rst_out_err", 32'(out_err[0]), 32'h0);
        chk("rst_in_ready", 32'(in_ready[0]), 32'h1);
        @(posedge clk);
        #1;

        lat_on = 1'b1;
        send(0, 32'h80, 2, 0, 32'h20, 1'b0);
        wait_empty(0);

        t0 = cyc;
        send(0, 32'h90, 3, 2, 32'hF2, 1'b0);
        send(0, 32'h81, 1, 3, 32'hC0, 1'b0);
        send(0, 32'h81, 4, 4, 32'h18, 1'b0);
        send(0, 32'hFF, 7, 1, 32'h80, 1'b0);
        send(0, 32'h0F, 4, 0, 32'h00, 1'b0);
        chk("b2b_cycles", 32'(cyc - t0), 32'h5);
        wait_empty(0);

        lat_on = 1'b0;
        out_ready[0] = 1'b0;
        fork
            begin
                send(0, 32'hF0, 1, 0, 32'h78, 1'b0);
                send(0, 32'h0F, 2, 1, 32'h3C, 1'b0);
                send(0, 32'h12, 4, 3, 32'h21, 1'b0);
                send(0, 32'h40, 6, 2, 32'h01, 1'b0);
            end
            begin
                int k = 0;
                @(negedge clk);
                while (!out_valid[0] && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_valid", 32'(out_valid[0]), 32'h1);
                hold = out_data[0];
                repeat (5) begin
                    chk("bp_in_ready", 32'(in_ready[0]), 32'h0);
                    chk("bp_hold", out_data[0], hold);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        wait_empty(0);

        lat_on = 1'b1;
        send(0, 32'hA5, 3, 6, 32'hA5, 1'b1);
        send(0, 32'hA5, 3, 0, 32'h14, 1'b0);
        wait_empty(0);

        send(0, 32'h33, 1, 1, 32'h66, 1'b0);
        send(0, 32'h44, 2, 0, 32'h11, 1'b0);
        rst = 1'b1;
        sb[0].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_flush", 32'(out_valid[0]), 32'h0);
        end
        @(posedge clk);
        #1;
        send(0, 32'h01, 5, 1, 32'h20, 1'b0);
        wait_empty(0);

        send(1, 32'h8001, 1, 4, 32'h0003, 1'b0);
        wait_empty(1);
        send(2, 32'h8000_0000, 31, 0, 32'h1, 1'b0);
        send(2, 32'h8000_0000, 4, 2, 32'hF800_0000, 1'b0);
        wait_empty(2);

        lat_on = 1'b0;
        fork
            sweep(1);
            sweep(2);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
